arbitro_enrutador: RTL

ARBITRO_ENRUTADOR -- requirements
Module: arbitro_enrutador

---
 rtl/arbitro_enrutador_pkg.sv | 15 +
 rtl/arbitro_enrutador_codificador_prioridad.sv | 20 ++
 rtl/arbitro_enrutador.sv | 100 ++++++++++
 3 files changed

// File: rtl/arbitro_enrutador_pkg.sv
// Shared constants and helpers for the 4x4 arbiter/router.
// The destination output of a word is carried in its two top bits.
package arbitro_enrutador_pkg;

    localparam int NUM_PORTS = 4;
    localparam int DATA_W    = 10;
    localparam int CNT_W     = 5;
    localparam int DEST_MSB  = 9;
    localparam int DEST_LSB  = 8;

    function automatic logic [NUM_PORTS-1:0] dest_onehot(input logic [DATA_W-1:0] word);
        return 4'b0001 << word[DEST_MSB:DEST_LSB];
    endfunction

endpackage

// File: rtl/arbitro_enrutador_codificador_prioridad.sv
// Fixed-priority encoder: input 0 wins. Purely combinational one-hot grant.
module codificador_prioridad (
    input  logic [3:0] eligible,
    output logic [3:0] grant,
    output logic       grant_valid
);

    always_comb begin
        grant = 4'b0000;
        casez (eligible)
            4'b???1: grant = 4'b0001;
            4'b??10: grant = 4'b0010;
            4'b?100: grant = 4'b0100;
            4'b1000: grant = 4'b1000;
            default: grant = 4'b0000;
        endcase
        grant_valid = |eligible;
    end

endmodule

// File: rtl/arbitro_enrutador.sv
// Routes head words of four FWFT input FIFOs to four output FIFOs chosen by
// bits [9:8], with strict priority, per-output push counters and a read port.
module arbitro_enrutador
    import arbitro_enrutador_pkg::*;
#(
    parameter int NUM_PORTS = arbitro_enrutador_pkg::NUM_PORTS,
    parameter int DATA_W    = arbitro_enrutador_pkg::DATA_W,
    parameter int CNT_W     = arbitro_enrutador_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_PORTS-1:0] fifo_empty_in,
    input  logic [DATA_W-1:0]    data_in0,
    input  logic [DATA_W-1:0]    data_in1,
    input  logic [DATA_W-1:0]    data_in2,
    input  logic [DATA_W-1:0]    data_in3,
    input  logic [NUM_PORTS-1:0] fifo_almost_full_out,
    output logic [NUM_PORTS-1:0] pop_in,
    output logic [NUM_PORTS-1:0] push_out,
    output logic [DATA_W-1:0]    data_out,
    output logic                 idle,
    input  logic                 req,
    input  logic [1:0]           idx,
    output logic                 valid_contador,
    output logic [CNT_W-1:0]     contador_out
);

    logic [DATA_W-1:0]    words [NUM_PORTS];
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] grant;
    logic                 grant_valid;
    logic [DATA_W-1:0]    sel_word;
    logic [CNT_W-1:0]     count [NUM_PORTS];

    assign words[0] = data_in0;
    assign words[1] = data_in1;
    assign words[2] = data_in2;
    assign words[3] = data_in3;

    // Almost-full already leaves one word of margin, so in-flight pushes are not tracked.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = enable & ~reset & ~fifo_empty_in[i]
                        & ~fifo_almost_full_out[words[i][DEST_MSB:DEST_LSB]];
        end
    end

    codificador_prioridad u_codificador (
        .eligible    (eligible),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) sel_word = words[i];
        end
    end

    assign pop_in = grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            push_out <= '0;
            data_out <= '0;
            idle     <= 1'b0;
        end else begin
            push_out <= grant_valid ? dest_onehot(sel_word) : '0;
            if (grant_valid) data_out <= sel_word;
            idle     <= (fifo_empty_in == 4'b1111) && !grant_valid && (push_out == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < NUM_PORTS; j++) count[j] <= '0;
        end else begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (push_out[j]) count[j] <= count[j] + 1'b1;
            end
        end
    end

    // Reads sample the counter before this cycle's increment lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_contador <= 1'b0;
            contador_out   <= '0;
        end else if (req && idle) begin
            valid_contador <= 1'b1;
            contador_out   <= count[idx];
        end else begin
            valid_contador <= 1'b0;
            contador_out   <= '0;
        end
    end

endmodule
